// File: rtl/adder_operand_sequencer_pkg.sv
// Shared constants for the adder operand sequencer: operand width and
// state encodings, which are also visible on the state output.
package adder_operand_sequencer_pkg;

   localparam int OPW = 4;

   typedef logic [OPW-1:0] operand_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HAVE_A = 2'd1;
   localparam logic [1:0] ST_CALC   = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

endpackage

// File: rtl/adder_operand_sequencer_btn_debounce.sv
// Button debouncer: the accepted level follows the raw input only after it
// has differed for DEBOUNCE_CYCLES consecutive cycles. A rising flip of the
// accepted level produces a single-cycle registered pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       pulse_q, pulse_d;

   // Count disagreement cycles; flip the accepted level on the Nth one.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      if (btn_raw == level_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = 8'd0;
         level_d = ~level_q;
         pulse_d = ~level_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Debounce state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 8'd0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = pulse_q;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for the 4-bit parallel adder.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for operand A
// HAVE_A    | A loaded, waiting for operand B
// CALC      | single cycle, adder outputs captured at its end
// RESULT    | result valid; ENTER chains result + switches
module adder_operand_sequencer
   import adder_operand_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit STICKY_OVF      = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] sw_data,
   input  logic           btn_enter,
   input  logic           btn_clear,
   output logic [OPW-1:0] a_out,
   output logic [OPW-1:0] b_out,
   input  logic [OPW-1:0] sum_in,
   input  logic           c4_in,
   input  logic           ovf_in,
   output logic [OPW-1:0] result,
   output logic           carry_flag,
   output logic           ovf_flag,
   output logic           result_valid,
   output logic [1:0]     state
);

   logic     enter_p, clear_p;
   logic     enter_lvl, clear_lvl;
   logic     unused_lvl;

   logic [1:0] state_q, state_d;
   operand_t   reg_a_q, reg_a_d;
   operand_t   reg_b_q, reg_b_d;
   operand_t   result_q, result_d;
   logic       carry_q, carry_d;
   logic       ovf_q, ovf_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_enter),
      .level      (enter_lvl),
      .rise_pulse (enter_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_clear),
      .level      (clear_lvl),
      .rise_pulse (clear_p)
   );

   // Accepted levels are not needed here; only the edges drive the FSM.
   assign unused_lvl = enter_lvl ^ clear_lvl;

   // Next-state and datapath decode; CLEAR wins over ENTER everywhere.
   always_comb begin
      state_d  = state_q;
      reg_a_d  = reg_a_q;
      reg_b_d  = reg_b_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      if (clear_p) begin
         state_d  = ST_IDLE;
         reg_a_d  = '0;
         reg_b_d  = '0;
         result_d = '0;
         carry_d  = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enter_p) begin
                  reg_a_d = sw_data;
                  state_d = ST_HAVE_A;
               end
            end
            ST_HAVE_A: begin
               if (enter_p) begin
                  reg_b_d = sw_data;
                  state_d = ST_CALC;
               end
            end
            ST_CALC: begin
               result_d = sum_in;
               carry_d  = c4_in;
               if (STICKY_OVF) ovf_d = ovf_q | ovf_in;
               else            ovf_d = ovf_in;
               state_d  = ST_RESULT;
            end
            default: begin
               if (enter_p) begin
                  reg_a_d = result_q;
                  reg_b_d = sw_data;
                  state_d = ST_CALC;
               end
            end
         endcase
      end
   end

   // State and datapath registers; reset overrides any pending capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         reg_a_q  <= '0;
         reg_b_q  <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         reg_a_q  <= reg_a_d;
         reg_b_q  <= reg_b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign a_out        = reg_a_q;
   assign b_out        = reg_b_q;
   assign result       = result_q;
   assign carry_flag   = carry_q;
   assign ovf_flag     = ovf_q;
   assign result_valid = (state_q == ST_RESULT);
   assign state        = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer with a 4-bit adder modelled between
// a_out/b_out and sum_in/c4_in/ovf_in. Two instances share stimulus: one
// with sticky overflow, one without.
module tb_adder_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_data;
   logic       btn_enter, btn_clear;

   logic [3:0] a_out, b_out, sum_in, result;
   logic       c4_in, ovf_in, carry_flag, ovf_flag, result_valid;
   logic [1:0] state;

   logic [3:0] a2, b2, sum2, result2;
   logic       c42, ovf2, carry2, ovf_flag2, rv2;
   logic [1:0] state2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] exp_a, exp_b, exp_res;
   logic       exp_c, exp_ovf, exp_ovf0;
   logic [1:0] exp_st;

   always #5 clk = ~clk;

   // 4-bit ripple adder behaviour: carry-out and two's-complement overflow
   assign {c4_in, sum_in} = {1'b0, a_out} + {1'b0, b_out};
   assign ovf_in = (a_out[3] == b_out[3]) && (sum_in[3] != a_out[3]);
   assign {c42, sum2} = {1'b0, a2} + {1'b0, b2};
   assign ovf2 = (a2[3] == b2[3]) && (sum2[3] != a2[3]);

   adder_operand_sequencer #(.DEBOUNCE_CYCLES(4), .STICKY_OVF(1'b1)) dut (
      .clk(clk), .rst(rst), .sw_data(sw_data), .btn_enter(btn_enter), .btn_clear(btn_clear),
      .a_out(a_out), .b_out(b_out), .sum_in(sum_in), .c4_in(c4_in), .ovf_in(ovf_in),
      .result(result), .carry_flag(carry_flag), .ovf_flag(ovf_flag),
      .result_valid(result_valid), .state(state)
   );

   adder_operand_sequencer #(.DEBOUNCE_CYCLES(4), .STICKY_OVF(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .sw_data(sw_data), .btn_enter(btn_enter), .btn_clear(btn_clear),
      .a_out(a2), .b_out(b2), .sum_in(sum2), .c4_in(c42), .ovf_in(ovf2),
      .result(result2), .carry_flag(carry2), .ovf_flag(ovf_flag2),
      .result_valid(rv2), .state(state2)
   );

   wire [16:0] act_snap = {a_out, b_out, result, carry_flag, ovf_flag, result_valid, state};

   function automatic logic [16:0] exp_snap();
      return {exp_a, exp_b, exp_res, exp_c, exp_ovf, (exp_st == 2'd3), exp_st};
   endfunction

   // ---------------- reference model (arithmetic on operand values) -------
   task automatic m_clear();
      exp_a = 0; exp_b = 0; exp_res = 0; exp_c = 0; exp_ovf = 0; exp_ovf0 = 0; exp_st = 0;
   endtask

   task automatic m_add();
      int s, sa, sb, ss;
      bit ov;
      s  = int'(exp_a) + int'(exp_b);
      sa = (exp_a >= 8) ? int'(exp_a) - 16 : int'(exp_a);
      sb = (exp_b >= 8) ? int'(exp_b) - 16 : int'(exp_b);
      ss = sa + sb;
      ov = (ss > 7) || (ss < -8);
      exp_res  = 4'(s % 16);
      exp_c    = (s > 15);
      exp_ovf  = exp_ovf | ov;
      exp_ovf0 = ov;
   endtask

   task automatic m_enter(input logic [3:0] sw);
      if (exp_st == 2'd0) begin
         exp_a = sw; exp_st = 2'd1;
      end else if (exp_st == 2'd1) begin
         exp_b = sw; m_add(); exp_st = 2'd3;
      end else begin
         exp_a = exp_res; exp_b = sw; m_add(); exp_st = 2'd3;
      end
   endtask

   // ---------------- stimulus helpers (drive only) ------------------------
   task automatic do_enter(input logic [3:0] sw);
      @(negedge clk);
      sw_data = sw; btn_enter = 1'b1;
      repeat (6) @(negedge clk);
      btn_enter = 1'b0;
      repeat (6) @(negedge clk);
      m_enter(sw);
   endtask

   task automatic do_clear();
      @(negedge clk);
      btn_clear = 1'b1;
      repeat (6) @(negedge clk);
      btn_clear = 1'b0;
      repeat (6) @(negedge clk);
      m_clear();
   endtask

   // ---------------- tests ------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; sw_data = 4'hA; btn_enter = 1'b0; btn_clear = 1'b0;
      repeat (3) @(negedge clk);
      m_clear();
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", act_snap, exp_snap());
      end
      n_checks++;
      if ({result2, carry2, ovf_flag2, rv2, state2} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_ns: got %h expected 0", {result2, carry2, ovf_flag2, rv2, state2});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_latency();
      int k;
      do_clear();
      do_enter(4'b0101);
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL basic_load_a: got %h expected %h", act_snap, exp_snap());
      end
      sw_data = 4'b0011; btn_enter = 1'b1;
      k = 0;
      while (state === 2'd1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (state !== 2'd2 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_calc: got state=%0d valid=%b expected state=2 valid=0 (after %0d cycles)", state, result_valid, k);
      end
      @(negedge clk);
      m_enter(4'b0011);
      n_checks++;
      if (act_snap !== exp_snap() || {result, carry_flag, ovf_flag} !== 6'b1000_0_1) begin
         n_fail++;
         $display("FAIL latency_result: got %h expected %h", act_snap, exp_snap());
      end
      repeat (6) @(negedge clk);
      btn_enter = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL result_hold: got %h expected %h", act_snap, exp_snap());
      end
   endtask

   task automatic test_carry();
      do_clear();
      do_enter(4'b1111);
      do_enter(4'b0001);
      n_checks++;
      if (act_snap !== exp_snap() || {result, carry_flag, ovf_flag} !== 6'b0000_1_0) begin
         n_fail++;
         $display("FAIL carry_out: got %h expected %h", act_snap, exp_snap());
      end
   endtask

   task automatic test_chain();
      do_clear();
      do_enter(4'b0010);
      do_enter(4'b0011);
      n_checks++;
      if (act_snap !== exp_snap() || result !== 4'b0101) begin
         n_fail++;
         $display("FAIL chain_first: got %h expected %h", act_snap, exp_snap());
      end
      do_enter(4'b0100);
      n_checks++;
      if (act_snap !== exp_snap() || {result, ovf_flag} !== 5'b1001_1) begin
         n_fail++;
         $display("FAIL chain_second: got %h expected %h", act_snap, exp_snap());
      end
      do_enter(4'b0001);
      n_checks++;
      if (act_snap !== exp_snap() || {result, ovf_flag} !== 5'b1010_1) begin
         n_fail++;
         $display("FAIL chain_sticky: got %h expected %h", act_snap, exp_snap());
      end
      n_checks++;
      if ({result2, ovf_flag2} !== {exp_res, exp_ovf0} || ovf_flag2 !== 1'b0) begin
         n_fail++;
         $display("FAIL chain_nonsticky: got %h expected %h", {result2, ovf_flag2}, {exp_res, exp_ovf0});
      end
   endtask

   task automatic test_debounce();
      logic [3:0] sw;
      logic       pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_clear();
      @(negedge clk);
      sw_data = 4'hC; btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      btn_enter = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL short_press: got %h expected %h", act_snap, exp_snap());
      end
      for (int i = 0; i < 6; i++) begin
         btn_enter = pat[i];
         @(negedge clk);
      end
      btn_enter = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL bounce_press: got %h expected %h", act_snap, exp_snap());
      end
      sw = 4'($urandom_range(0, 15));
      sw_data = sw; btn_enter = 1'b1;
      repeat (20) @(negedge clk);
      m_enter(sw);
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL long_hold_one_load: got %h expected %h", act_snap, exp_snap());
      end
      btn_enter = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_clear_enter_same();
      do_clear();
      do_enter(4'b0110);
      @(negedge clk);
      sw_data = 4'b1001; btn_enter = 1'b1; btn_clear = 1'b1;
      repeat (6) @(negedge clk);
      btn_enter = 1'b0; btn_clear = 1'b0;
      repeat (6) @(negedge clk);
      m_clear();
      n_checks++;
      if (act_snap !== exp_snap()) begin
         n_fail++;
         $display("FAIL clear_over_enter: got %h expected %h", act_snap, exp_snap());
      end
   endtask

   task automatic test_rst_in_calc();
      int k;
      do_clear();
      do_enter(4'b0111);
      do_enter(4'b0111);
      do_enter(4'b0011);
      sw_data = 4'b0101; btn_enter = 1'b1;
      k = 0;
      while (state !== 2'd2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (state !== 2'd2) begin
         n_fail++;
         $display("FAIL reach_calc: got state=%0d expected 2", state);
      end
      rst = 1'b1; btn_enter = 1'b0;
      @(negedge clk);
      m_clear();
      n_checks++;
      if (act_snap !== exp_snap() || {result2, ovf_flag2, state2} !== 7'd0) begin
         n_fail++;
         $display("FAIL rst_in_calc: got %h expected %h", act_snap, exp_snap());
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_random();
      logic [3:0] sw;
      do_clear();
      for (int i = 0; i < 25; i++) begin
         sw = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) do_clear();
         else                           do_enter(sw);
         n_checks++;
         if (act_snap !== exp_snap()) begin
            n_fail++;
            $display("FAIL random_%0d: got %h expected %h", i, act_snap, exp_snap());
         end
         n_checks++;
         if ({result2, carry2, ovf_flag2} !== {exp_res, exp_c, exp_ovf0}) begin
            n_fail++;
            $display("FAIL random_ns_%0d: got %h expected %h", i, {result2, carry2, ovf_flag2}, {exp_res, exp_c, exp_ovf0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_carry();
      test_chain();
      test_debounce();
      test_clear_enter_same();
      test_rst_in_calc();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
